// File: rtl/i2s_tx_module.sv
// I2S master transmitter: buffers one stereo pair from a valid/ready stream and
// serialises it MSB-first with bck/lrck derived from clk_i by a fixed divider.
module i2s_tx_module #(
    parameter int FRAME_RES = 32,
    parameter int DATA_RES  = 24,
    parameter int CLK_DIV   = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [DATA_RES-1:0] left_i,
    input  logic [DATA_RES-1:0] right_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic                bck_o,
    output logic                lrck_o,
    output logic                dat_o,
    output logic                underrun_o
);

    if (DATA_RES < 1 || DATA_RES >= FRAME_RES || CLK_DIV < 1) begin : g_param_check
        $error("i2s_tx_module: illegal DATA_RES/FRAME_RES/CLK_DIV combination");
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(2 * FRAME_RES);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * FRAME_RES - 1);
    localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(FRAME_RES);
    localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(DATA_RES);

    logic [DIV_W-1:0]    div_q, div_d;
    logic                bck_q, bck_d;
    logic                lrck_q, lrck_d;
    logic                dat_q, dat_d;
    logic                ur_q, ur_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                hold_full_q, hold_full_d;
    logic [DATA_RES-1:0] hold_l_q, hold_l_d;
    logic [DATA_RES-1:0] hold_r_q, hold_r_d;
    logic [DATA_RES-1:0] sh_l_q, sh_l_d;
    logic [DATA_RES-1:0] sh_r_q, sh_r_d;

    logic             div_tc;
    logic             fall;
    logic             xfer;
    logic [CNT_W-1:0] k_next;
    logic [CNT_W-1:0] p_next;
    logic             right_slot;
    logic             data_slot;
    logic             frame_start;

    always_comb begin
        div_tc      = (div_q == DIV_LAST);
        fall        = div_tc & bck_q;
        xfer        = valid_i & ~hold_full_q;
        k_next      = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;
        right_slot  = (k_next >= SLOT_LEN);
        p_next      = right_slot ? k_next - SLOT_LEN : k_next;
        data_slot   = (p_next != '0) && (p_next <= DATA_LEN);
        frame_start = fall && (k_next == '0);
    end

    always_comb begin
        div_d       = div_tc ? '0 : div_q + 1'b1;
        bck_d       = div_tc ? ~bck_q : bck_q;
        lrck_d      = lrck_q;
        dat_d       = dat_q;
        ur_d        = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        sh_l_d      = sh_l_q;
        sh_r_d      = sh_r_q;

        if (xfer) begin
            hold_l_d    = left_i;
            hold_r_d    = right_i;
            hold_full_d = 1'b1;
        end

        if (fall) begin
            bit_cnt_d = k_next;
            lrck_d    = right_slot;
            dat_d     = 1'b0;
            if (frame_start) begin
                // An empty buffer sends a silent frame; a same-edge transfer waits for the next one.
                if (hold_full_q) begin
                    sh_l_d      = hold_l_q;
                    sh_r_d      = hold_r_q;
                    hold_full_d = 1'b0;
                end else begin
                    sh_l_d = '0;
                    sh_r_d = '0;
                    ur_d   = 1'b1;
                end
            end else if (data_slot) begin
                if (right_slot) begin
                    dat_d  = sh_r_q[DATA_RES-1];
                    sh_r_d = sh_r_q << 1;
                end else begin
                    dat_d  = sh_l_q[DATA_RES-1];
                    sh_l_d = sh_l_q << 1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q       <= '0;
            bck_q       <= 1'b0;
            lrck_q      <= 1'b1;
            dat_q       <= 1'b0;
            ur_q        <= 1'b0;
            bit_cnt_q   <= CNT_LAST;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            sh_l_q      <= '0;
            sh_r_q      <= '0;
        end else begin
            div_q       <= div_d;
            bck_q       <= bck_d;
            lrck_q      <= lrck_d;
            dat_q       <= dat_d;
            ur_q        <= ur_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            sh_l_q      <= sh_l_d;
            sh_r_q      <= sh_r_d;
        end
    end

    assign ready_o    = ~hold_full_q;
    assign bck_o      = bck_q;
    assign lrck_o     = lrck_q;
    assign dat_o      = dat_q;
    assign underrun_o = ur_q;

endmodule

// File: tb/tb_i2s_tx_module.sv
// Directed bench for i2s_tx_module with a behavioural I2S receiver model that
// rebuilds each 32-bit slot from bck/lrck/dat.
module tb_i2s_tx_module;
    localparam int FR        = 32;
    localparam int DR        = 24;
    localparam int CD        = 2;
    localparam int FRAME_CLK = 2 * FR * 2 * CD;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [DR-1:0] left_i = '0;
    logic [DR-1:0] right_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o, bck_o, lrck_o, dat_o, underrun_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    i2s_tx_module #(.FRAME_RES(FR), .DATA_RES(DR), .CLK_DIV(CD)) dut (
        .clk_i(clk), .rst_i(rst_i), .left_i(left_i), .right_i(right_i),
        .valid_i(valid_i), .ready_o(ready_o), .bck_o(bck_o), .lrck_o(lrck_o),
        .dat_o(dat_o), .underrun_o(underrun_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Receiver model and line monitors, sampled on the falling clk edge.
    logic        prev_bck = 1'b0, prev_lrck = 1'b1, prev_ur = 1'b0;
    logic        rx_last = 1'b1, rx_sync = 1'b0, rx_have_l = 1'b0;
    logic [31:0] rx_word = '0, rx_left = '0;
    logic [63:0] rx_pairs [0:255];
    int rx_pos = 0, rx_cnt = 0;
    int ur_cnt = 0, ur_wide = 0, ur_misalign = 0, dat_ones = 0, bck_tog = 0;
    int ur_cyc = -1, ur_period = 0, lrck_fall_cyc = -1, lrck_period = 0;

    initial forever begin
        @(negedge clk);
        if (underrun_o) begin
            ur_cnt++;
            if (prev_ur) ur_wide++;
            if (!(prev_lrck && !lrck_o)) ur_misalign++;
            if (ur_cyc >= 0) ur_period = cyc - ur_cyc;
            ur_cyc = cyc;
        end
        if (dat_o) dat_ones++;
        if (bck_o != prev_bck) bck_tog++;
        if (prev_lrck && !lrck_o) begin
            if (lrck_fall_cyc >= 0) lrck_period = cyc - lrck_fall_cyc;
            lrck_fall_cyc = cyc;
        end
        if (rst_i) begin
            rx_sync = 1'b0; rx_have_l = 1'b0; rx_last = 1'b1;
            ur_cyc = -1; lrck_fall_cyc = -1;
        end else if (bck_o && !prev_bck) begin
            if (rx_last != lrck_o) begin
                rx_pos = 0;
                if (!lrck_o) rx_sync = 1'b1;
            end
            rx_last = lrck_o;
            if (rx_sync) begin
                rx_word = {rx_word[30:0], dat_o};
                if (rx_pos == FR - 1) begin
                    if (!lrck_o) begin
                        rx_left = rx_word;
                        rx_have_l = 1'b1;
                    end else if (rx_have_l) begin
                        rx_pairs[rx_cnt % 256] = {rx_left, rx_word};
                        rx_cnt++;
                        rx_have_l = 1'b0;
                    end
                end
            end
            rx_pos++;
        end
        prev_bck = bck_o; prev_lrck = lrck_o; prev_ur = underrun_o;
    end

    function automatic logic [31:0] slot(input logic [DR-1:0] d);
        return {1'b0, d, {(FR - DR - 1){1'b0}}};
    endfunction

    logic [DR-1:0] exp_l [0:15];
    logic [DR-1:0] exp_r [0:15];
    int xfer_cyc [0:15];
    int sent = 0;

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1; valid_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic stream(input int n, input bit rnd);
        logic will;
        int guard;
        sent = 0; guard = 0;
        left_i  = rnd ? DR'($urandom) : DR'(24'h100000);
        right_i = rnd ? DR'($urandom) : DR'(24'h200000);
        valid_i = 1'b1;
        while (sent < n && guard < (n + 2) * FRAME_CLK) begin
            @(negedge clk);
            will = ready_o;
            @(posedge clk); #1;
            guard++;
            if (will) begin
                xfer_cyc[sent] = cyc; exp_l[sent] = left_i; exp_r[sent] = right_i;
                sent++;
                left_i  = rnd ? DR'($urandom) : DR'(24'h100000 + sent);
                right_i = rnd ? DR'($urandom) : DR'(24'h200000 + sent);
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        logic eb, el, eu;
        do_reset();
        for (int n = 0; n <= 8; n++) begin
            @(negedge clk);
            eb = ((n / 2) % 2) == 1; el = (n < 4); eu = (n == 4);
            checks++; if (bck_o !== eb) begin errors++; $display("FAIL reset_bck n=%0d got=%b exp=%b", n, bck_o, eb); end
            checks++; if (lrck_o !== el) begin errors++; $display("FAIL reset_lrck n=%0d got=%b exp=%b", n, lrck_o, el); end
            checks++; if (underrun_o !== eu) begin errors++; $display("FAIL reset_underrun n=%0d got=%b exp=%b", n, underrun_o, eu); end
            checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready n=%0d got=%b exp=1", n, ready_o); end
            checks++; if (dat_o !== 1'b0) begin errors++; $display("FAIL reset_dat n=%0d got=%b exp=0", n, dat_o); end
        end
    endtask

    task automatic test_single_pair();
        int base, ur0, t;
        do_reset();
        base = rx_cnt; ur0 = ur_cnt;
        left_i = 24'hA5A5A5; right_i = 24'h5A5A5A; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL single_ready_low got=%b exp=0", ready_o); end
        repeat (2) @(negedge clk);
        @(negedge clk);
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL single_ready_after_load got=%b exp=1", ready_o); end
        checks++; if (lrck_o !== 1'b0) begin errors++; $display("FAIL single_lrck_start got=%b exp=0", lrck_o); end
        t = 0;
        while (rx_cnt <= base && t < 2 * FRAME_CLK) begin @(posedge clk); t++; end
        checks++;
        if (rx_cnt <= base) begin
            errors++; $display("FAIL single_timeout got=%0d pairs exp=1", rx_cnt - base);
        end else if (rx_pairs[base % 256] !== {slot(24'hA5A5A5), slot(24'h5A5A5A)}) begin
            errors++; $display("FAIL single_pair got=%h exp=%h", rx_pairs[base % 256], {slot(24'hA5A5A5), slot(24'h5A5A5A)});
        end
        checks++; if (ur_cnt - ur0 !== 0) begin errors++; $display("FAIL single_underrun got=%0d exp=0", ur_cnt - ur0); end
    endtask

    task automatic test_underrun();
        int s_ur, s_bck, s_dat, s_wide, s_mis, base;
        do_reset();
        repeat (16) @(posedge clk);
        s_ur = ur_cnt; s_bck = bck_tog; s_dat = dat_ones; s_wide = ur_wide; s_mis = ur_misalign; base = rx_cnt;
        repeat (3 * FRAME_CLK) @(posedge clk);
        checks++; if (ur_cnt - s_ur !== 3) begin errors++; $display("FAIL underrun_count got=%0d exp=3", ur_cnt - s_ur); end
        checks++; if (bck_tog - s_bck !== 3 * FRAME_CLK / 2) begin errors++; $display("FAIL underrun_bck_toggles got=%0d exp=%0d", bck_tog - s_bck, 3 * FRAME_CLK / 2); end
        checks++; if (dat_ones - s_dat !== 0) begin errors++; $display("FAIL underrun_dat got=%0d ones exp=0", dat_ones - s_dat); end
        checks++; if (ur_wide - s_wide !== 0) begin errors++; $display("FAIL underrun_width got=%0d wide exp=0", ur_wide - s_wide); end
        checks++; if (ur_misalign - s_mis !== 0) begin errors++; $display("FAIL underrun_align got=%0d exp=0", ur_misalign - s_mis); end
        checks++; if (ur_period !== FRAME_CLK) begin errors++; $display("FAIL underrun_period got=%0d exp=%0d", ur_period, FRAME_CLK); end
        checks++; if (lrck_period !== FRAME_CLK) begin errors++; $display("FAIL lrck_period got=%0d exp=%0d", lrck_period, FRAME_CLK); end
        checks++;
        if (rx_cnt - base < 2) begin
            errors++; $display("FAIL underrun_rx_count got=%0d exp>=2", rx_cnt - base);
        end else if (rx_pairs[(rx_cnt - 1) % 256] !== 64'h0) begin
            errors++; $display("FAIL underrun_rx_pair got=%h exp=0", rx_pairs[(rx_cnt - 1) % 256]);
        end
    endtask

    task automatic test_backpressure();
        int base, ur0, t;
        do_reset();
        base = rx_cnt; ur0 = ur_cnt;
        stream(5, 1'b0);
        checks++; if (sent !== 5) begin errors++; $display("FAIL bp_sent got=%0d exp=5", sent); end
        @(negedge clk);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b exp=0", ready_o); end
        checks++; if (xfer_cyc[1] - xfer_cyc[0] !== 4) begin errors++; $display("FAIL bp_first_gap got=%0d exp=4", xfer_cyc[1] - xfer_cyc[0]); end
        for (int i = 2; i < 5; i++) begin
            checks++;
            if (xfer_cyc[i] - xfer_cyc[i-1] !== FRAME_CLK) begin
                errors++; $display("FAIL bp_gap i=%0d got=%0d exp=%0d", i, xfer_cyc[i] - xfer_cyc[i-1], FRAME_CLK);
            end
        end
        t = 0;
        while (rx_cnt < base + 5 && t < 3 * FRAME_CLK) begin @(posedge clk); t++; end
        checks++; if (ur_cnt - ur0 !== 0) begin errors++; $display("FAIL bp_underrun got=%0d exp=0", ur_cnt - ur0); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_cnt < base + i + 1) begin
                errors++; $display("FAIL bp_missing i=%0d got=%0d pairs", i, rx_cnt - base);
            end else if (rx_pairs[(base + i) % 256] !== {slot(24'h100000 + DR'(i)), slot(24'h200000 + DR'(i))}) begin
                errors++; $display("FAIL bp_pair i=%0d got=%h exp=%h", i, rx_pairs[(base + i) % 256],
                                   {slot(24'h100000 + DR'(i)), slot(24'h200000 + DR'(i))});
            end
        end
    endtask

    task automatic test_back_to_back();
        int base, t;
        do_reset();
        base = rx_cnt;
        stream(8, 1'b1);
        t = 0;
        while (rx_cnt < base + 8 && t < 3 * FRAME_CLK) begin @(posedge clk); t++; end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx_cnt < base + i + 1) begin
                errors++; $display("FAIL loop_missing i=%0d got=%0d pairs", i, rx_cnt - base);
            end else if (rx_pairs[(base + i) % 256] !== {slot(exp_l[i]), slot(exp_r[i])}) begin
                errors++; $display("FAIL loop_pair i=%0d got=%h exp=%h", i, rx_pairs[(base + i) % 256],
                                   {slot(exp_l[i]), slot(exp_r[i])});
            end
        end
    endtask

    task automatic test_reset_mid();
        int base, s_ur, s_dat, t;
        do_reset();
        stream(2, 1'b0);
        repeat (160) @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        checks++; if (bck_o !== 1'b0) begin errors++; $display("FAIL mid_bck got=%b exp=0", bck_o); end
        checks++; if (lrck_o !== 1'b1) begin errors++; $display("FAIL mid_lrck got=%b exp=1", lrck_o); end
        checks++; if (dat_o !== 1'b0) begin errors++; $display("FAIL mid_dat got=%b exp=0", dat_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", ready_o); end
        checks++; if (underrun_o !== 1'b0) begin errors++; $display("FAIL mid_underrun got=%b exp=0", underrun_o); end
        base = rx_cnt; s_ur = ur_cnt; s_dat = dat_ones;
        t = 0;
        while (rx_cnt <= base && t < 2 * FRAME_CLK) begin @(posedge clk); t++; end
        checks++;
        if (rx_cnt <= base) begin
            errors++; $display("FAIL mid_timeout got=%0d pairs exp=1", rx_cnt - base);
        end else if (rx_pairs[base % 256] !== 64'h0) begin
            errors++; $display("FAIL mid_pair got=%h exp=0", rx_pairs[base % 256]);
        end
        checks++; if (ur_cnt - s_ur !== 1) begin errors++; $display("FAIL mid_underrun_pulse got=%0d exp=1", ur_cnt - s_ur); end
        checks++; if (dat_ones - s_dat !== 0) begin errors++; $display("FAIL mid_dat_ones got=%0d exp=0", dat_ones - s_dat); end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_underrun();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
